pipe_stage_skid: RTL
====================

// Module: pipe_stage_skid
// PURPOSE
//   Generic parametrised inter-stage pipeline register for the MIPS32 core; replaces per-stage
//   hand-written registers such as the memory/writeback register. Carries a control field and a
//   data payload between two stages with a valid/ready handshake.
//   Has a 2-entry skid buffer, so back-pressure is fully registered, plus a flush input.
//   Bubbles present an all-CTRL_BUBBLE control field so no write-enable can leak downstream.
// PARAMETERS
//   CTRL_W       4          width of control field (e.g. {MemtoReg[1:0],RegWrite,MemWrite})
//   DATA_W       69         width of payload (e.g. ReadData 32 + alu_result 32 + WriteRegister 5)
//   CTRL_BUBBLE  {CTRL_W{1'b0}}  control value driven on out_ctrl whenever out_valid=0
// PORTS
//   clk        in   1       rising-edge clock
//   reset_n    in   1       synchronous reset, active-low
//   flush      in   1       discard all held entries (branch/exception squash)
//   in_valid   in   1       upstream presents an entry
//   in_ready   out  1       stage can accept; registered, not combinationally derived from out_ready
//   in_ctrl    in   CTRL_W  upstream control field
//   in_data    in   DATA_W  upstream payload
//   out_valid  out  1       entry presented downstream
//   out_ready  in   1       downstream accepts
//   out_ctrl   out  CTRL_W  control field; CTRL_BUBBLE when out_valid=0
//   out_data   out  DATA_W  payload; holds last value when out_valid=0
//   occupancy  out  2       entries held (0,1,2)
// BEHAVIOUR
//   accept = in_valid & in_ready; drain = out_valid & out_ready; both are evaluated at posedge clk.
//   States: EMPTY (occ 0), FULL (main reg valid, occ 1), SKID (main+skid valid, occ 2).
//   Priority at each posedge: reset_n=0 > flush=1 > normal transitions.
//   Reset (reset_n=0 at posedge):
//     -> EMPTY; out_valid=0; out_ctrl=CTRL_BUBBLE; out_data=0; in_ready=1; occupancy=0.
//     Skid reg cleared to 0.
//   Flush: -> EMPTY; same outputs as reset except out_data holds; the entry offered in the same
//     cycle is dropped even if in_ready=1; in_ready=1 next cycle.
//   EMPTY: accept -> FULL, main<=in. Otherwise stay.
//   FULL:
//     accept&drain -> FULL, main<=in.
//     accept&!drain -> SKID, skid<=in, main holds.
//     !accept&drain -> EMPTY.
//     Otherwise hold.
//   SKID: in_ready=0, no accept. drain -> FULL, main<=skid. Otherwise hold.
//   in_ready = (state!=SKID), registered. Combinational paths: none in->out, none out_ready->in_ready.
//   Latency: accepted entry appears on out_* at the next posedge.
//   Throughput: 1 entry/cycle with out_ready held at 1.
//   Ordering: strict FIFO; skid entry is never presented before main entry.
//   out_ctrl = out_valid ? main_ctrl : CTRL_BUBBLE (mux after register; no extra cycle).
//   While out_valid=1 & out_ready=0, out_ctrl/out_data are stable until drained or flushed.
//   No arithmetic; occupancy never exceeds 2; no wrap.
// TESTING
//   Reset: reset_n=0 one cycle with in_valid=1 -> out_valid=0, out_ctrl=CTRL_BUBBLE, occupancy=0,
//     in_ready=1.
//   Streaming: out_ready=1, in_data=1..8 on consecutive cycles -> out_data=1..8 one cycle later,
//     no gaps, occupancy=1.
//   Back-pressure: out_ready=0 after entry 1, in_data=2 offered -> occupancy=2, in_ready=0;
//     raise out_ready -> out 1 then 2 in order, in_ready=1 one cycle after first drain.
//   Flush in SKID: occ=2 with in_ctrl=4'b0110 in both entries, flush=1 -> next cycle out_valid=0,
//     out_ctrl=0, occupancy=0; entries never appear.
//   Flush+accept same cycle: flush=1, in_valid=1, in_data=0xA5 -> 0xA5 never emitted.
//   Reset mid-stall: occ=2, reset_n=0 with flush=0 -> EMPTY, out_data=0; traffic resumes cleanly.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with a 2-entry skid buffer and flush.
// Back-pressure is fully registered: in_ready is a flop, never a function of out_ready.
module pipe_stage_skid #(
    parameter int unsigned        CTRL_W      = 4,
    parameter int unsigned        DATA_W      = 69,
    parameter logic [CTRL_W-1:0]  CTRL_BUBBLE = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {StEmpty, StFull, StSkid} state_e;

    state_e              state_q, state_d;
    logic                in_ready_q, in_ready_d;
    logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0]   main_data_q, main_data_d;
    logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0]   skid_data_q, skid_data_d;
    logic                accept, drain;

    assign out_valid = (state_q != StEmpty);
    assign accept    = in_valid & in_ready_q;
    assign drain     = out_valid & out_ready;

    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        if (flush) begin
            // Squash drops held entries and the one offered this cycle; payload regs hold.
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (accept) begin
                        state_d     = StFull;
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end
                end
                StFull: begin
                    if (accept && drain) begin
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end else if (accept) begin
                        state_d     = StSkid;
                        skid_ctrl_d = in_ctrl;
                        skid_data_d = in_data;
                    end else if (drain) begin
                        state_d = StEmpty;
                    end
                end
                StSkid: begin
                    if (drain) begin
                        state_d     = StFull;
                        main_ctrl_d = skid_ctrl_q;
                        main_data_d = skid_data_q;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
        in_ready_d = (state_d != StSkid);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= StEmpty;
            in_ready_q  <= 1'b1;
            main_ctrl_q <= CTRL_BUBBLE;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
        end
    end

    assign in_ready = in_ready_q;
    assign out_ctrl = out_valid ? main_ctrl_q : CTRL_BUBBLE;
    assign out_data = main_data_q;

    always_comb begin
        occupancy = 2'd0;
        unique case (state_q)
            StEmpty: occupancy = 2'd0;
            StFull:  occupancy = 2'd1;
            StSkid:  occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

endmodule
